// File: rtl/osc_freq_monitor.sv
// Oscillator frequency monitor: counts MEAS_IN rising edges over back-to-back CLK windows and flags out-of-range or lost oscillators.
// Optional macro OSC_FREQ_MONITOR_STICKY_LOSS_EN makes CLK_LOSS sticky until LOSS_CLR or RESET.
module osc_freq_monitor #(
  parameter int GATE_CYCLES  = 50000,
  parameter int CNT_W        = 16,
  parameter int MIN_COUNT    = 45,
  parameter int MAX_COUNT    = 55,
  parameter int LOSS_WINDOWS = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             MEAS_IN,
  input  logic             LOSS_CLR,
  output logic [CNT_W-1:0] FREQ_COUNT,
  output logic             FREQ_VALID,
  output logic             CLK_OOR,
  output logic             CLK_LOSS,
  output logic             BUSY,
  output logic [1:0]       fsm_state
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int LOSS_W = $clog2(LOSS_WINDOWS + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_COUNT);
  localparam logic [LOSS_W-1:0] LOSS_TGT  = LOSS_W'(LOSS_WINDOWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t state, state_next;

  logic              sync1, sync2, prev;
  logic              edge_hit;
  logic              flush_cnt, flush_next;
  logic [GATE_W-1:0] gate_cnt, gate_next;
  logic [CNT_W-1:0]  edge_cnt, edge_cnt_next;
  logic [CNT_W-1:0]  win_count;
  logic              terminal;
  logic [LOSS_W-1:0] low_run, low_run_next;
  logic              loss_set;

  // MEAS_IN is asynchronous: two flops for metastability, a third for edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= MEAS_IN;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_hit = sync2 & ~prev;

  // Saturating count including this cycle's edge; never wraps.
  assign win_count = (edge_hit && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_next;
      gate_cnt  <= gate_next;
      edge_cnt  <= edge_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    flush_next    = 1'b0;
    gate_next     = '0;
    edge_cnt_next = '0;
    terminal      = 1'b0;
    case (state)
      IDLE: begin
        if (ENABLE) state_next = FLUSH;
      end
      FLUSH: begin
        if (!ENABLE)        state_next = IDLE;
        else if (flush_cnt) state_next = MEASURE;
        else                flush_next = 1'b1;
      end
      MEASURE: begin
        // Terminal cycle restarts the window in place so windows run back to back.
        if (!ENABLE) begin
          state_next = IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          terminal = 1'b1;
        end else begin
          gate_next     = gate_cnt + 1'b1;
          edge_cnt_next = win_count;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    low_run_next = '0;
    if (win_count < MIN_C) begin
      low_run_next = (low_run == LOSS_TGT) ? low_run : low_run + 1'b1;
    end
  end

  assign loss_set = (low_run_next == LOSS_TGT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FREQ_COUNT <= '0;
      FREQ_VALID <= 1'b0;
      CLK_OOR    <= 1'b0;
      low_run    <= '0;
    end else begin
      FREQ_VALID <= terminal;
      if (terminal) begin
        FREQ_COUNT <= win_count;
        CLK_OOR    <= (win_count < MIN_C) || (win_count > MAX_C);
        low_run    <= low_run_next;
      end
    end
  end

`ifdef OSC_FREQ_MONITOR_STICKY_LOSS_EN
  // A window end that sets loss takes priority over a simultaneous clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CLK_LOSS <= 1'b0;
    end else if (terminal && loss_set) begin
      CLK_LOSS <= 1'b1;
    end else if (LOSS_CLR) begin
      CLK_LOSS <= 1'b0;
    end
  end
`else
  logic loss_clr_unused;
  assign loss_clr_unused = LOSS_CLR;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CLK_LOSS <= 1'b0;
    end else if (terminal) begin
      CLK_LOSS <= loss_set;
    end
  end
`endif

  assign BUSY      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: doc/osc_freq_monitor.md
# osc_freq_monitor

Fabric-side consumer of the on-chip oscillator outputs (RC 25/50 MHz, RC 1 MHz, crystal) routed through the fabric oscillator block. It counts rising edges of one oscillator output over a fixed window of fabric clock cycles. It reports the count and flags an out-of-range or lost oscillator. It sits beside the system builder and feeds status registers and clock-fail handling logic.

## Interface
- GATE_CYCLES, 50000: measurement window length in CLK cycles (≥ 4).
- CNT_W, 16: width of the edge counter and FREQ_COUNT.
- MIN_COUNT, 45: lowest in-range count per window.
- MAX_COUNT, 55: highest in-range count per window.
- LOSS_WINDOWS, 2: number of consecutive low windows (count < MIN_COUNT) that asserts CLK_LOSS (≥ 1).

- CLK  in  1  fabric clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  level; 1 = run back-to-back windows.
- MEAS_IN  in  1  oscillator output under test; asynchronous; frequency < CLK/2.
- LOSS_CLR  in  1  one-cycle pulse; clears sticky CLK_LOSS (used only with the macro).
- FREQ_COUNT  out  CNT_W  edge count of the last completed window.
- FREQ_VALID  out  1  one-cycle pulse when FREQ_COUNT updates.
- CLK_OOR  out  1  last completed window count < MIN_COUNT or > MAX_COUNT.
- CLK_LOSS  out  1  loss-of-oscillator flag.
- BUSY  out  1  FSM is not in IDLE.

## Operation
- Input path: MEAS_IN passes a 2-flop synchronizer, then a previous-value register. An edge is counted when sync=1 and prev=0.
- FSM states:
  - IDLE: counters held at 0. ENABLE=1 → FLUSH.
  - FLUSH: 2 cycles while the synchronizer settles; edges are ignored. Then → MEASURE.
  - MEASURE: gate counter runs 0..GATE_CYCLES-1, and edges are counted on every one of those cycles.
    - On the terminal cycle: FREQ_COUNT ← edge_cnt + edge_this_cycle, edge_cnt ← 0, gate ← 0. The FSM stays in MEASURE, so there is no dead cycle between windows.
- ENABLE=0 in FLUSH or MEASURE: abort to IDLE on the next edge. The partial window is discarded, there is no FREQ_VALID, and FREQ_COUNT/CLK_OOR/CLK_LOSS hold their values.
- Edge counter saturates at 2^CNT_W-1 and never wraps.
- Window-end evaluation, using the new count C:
  - CLK_OOR ← (C < MIN_COUNT) | (C > MAX_COUNT).
  - low_run increments (saturating at LOSS_WINDOWS) if C < MIN_COUNT; otherwise it goes to 0.
  - CLK_LOSS ← (low_run_next == LOSS_WINDOWS), subject to the sticky option below.
- Reset values: FREQ_COUNT=0, FREQ_VALID=0, CLK_OOR=0, CLK_LOSS=0, BUSY=0, FSM=IDLE, synchronizer flops=0, all counters 0.

## Timing
- MEAS_IN rising edge → counted edge: 3 CLK cycles (2 sync flops plus the edge register). Edges arriving within 3 cycles of window end count in the next window.
- ENABLE rise → first window start: 1 cycle (IDLE→FLUSH) + 2 FLUSH cycles.
- First FREQ_VALID: at cycle 3 + GATE_CYCLES after ENABLE is sampled high. After that, one FREQ_VALID every GATE_CYCLES cycles.
- FREQ_COUNT, CLK_OOR and CLK_LOSS all update in the same cycle FREQ_VALID is high, which is one cycle after the terminal gate cycle.
- Simultaneous LOSS_CLR and a window end that sets loss: set wins.
- Asynchronous RESET mid-window: all state returns to reset values immediately. The window restarts only after RESET falls and ENABLE=1.

## Configuration
- Macro: OSC_FREQ_MONITOR_STICKY_LOSS_EN.
- Defined: CLK_LOSS is sticky.
  - Set by the loss condition.
  - Cleared only by a LOSS_CLR pulse or by RESET; an in-range window does not clear it.
- Undefined: CLK_LOSS follows low_run each window, so the first window with C ≥ MIN_COUNT clears it. LOSS_CLR is ignored.

## Test plan
All scenarios use GATE_CYCLES=100, CNT_W=16, MIN_COUNT=8, MAX_COUNT=12, LOSS_WINDOWS=2.

- Nominal: MEAS_IN period 10 CLK cycles, ENABLE=1 → FREQ_VALID every 100 cycles, FREQ_COUNT=10, CLK_OOR=0, CLK_LOSS=0. The first VALID occurs at cycle 103 after ENABLE.
- Out of range: period 5 → FREQ_COUNT=20, CLK_OOR=1. Return to period 10 → next window FREQ_COUNT=10, CLK_OOR=0.
- Loss: MEAS_IN stuck at 0 → window 1 gives count 0, CLK_OOR=1, CLK_LOSS=0; window 2 gives CLK_LOSS=1. Restore period 10:
  - Without the macro, CLK_LOSS=0 after the next window.
  - With the macro, CLK_LOSS stays 1 until a LOSS_CLR pulse.
- Abort: drop ENABLE at gate cycle 50 → BUSY=0 next cycle, no FREQ_VALID, FREQ_COUNT keeps its prior value. Re-enable → a full 100-cycle window follows.
- Reset mid-window: assert RESET at gate cycle 60 with CLK_LOSS=1 → every output reads 0 immediately. After release, the first VALID arrives 103 cycles after ENABLE is sampled high.
- Saturation: CNT_W=4, period 4, GATE_CYCLES=100 → FREQ_COUNT=15, with no wrap.
